// File: rtl/te_sched_pkg.sv
// ============================================================================
// Module  : te_sched_pkg
// Brief   : Shared FSM state type, default channel count and index-width helper
//           for the tracking-channel scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package te_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        RETIRE = 2'd2
    } sched_state_t;

    localparam int unsigned c_CH_NUM_DEFAULT = 32;

    // A one-channel build still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/least_bit_n.sv
// ============================================================================
// Module  : least_bit_n
// Brief   : Combinational find-first-set searching upward from bit 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module least_bit_n
    import te_sched_pkg::*;
#(
    parameter int unsigned CH_NUM = c_CH_NUM_DEFAULT,
    parameter int unsigned IDX_W  = idx_width(CH_NUM)
) (
    input  logic [CH_NUM-1:0] i_vec,
    output logic [IDX_W-1:0]  o_index,
    output logic              o_active
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_index  = '0;
        o_active = |i_vec;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_index = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/te_channel_sched.sv
// ============================================================================
// Module  : te_channel_sched
// Brief   : Round-robin tracking-channel scheduler with valid/ready offer.
//           Optional per-channel overflow flags when TE_SCHED_OVERFLOW_EN is set.
// Revision: 1.0
// ============================================================================
`default_nettype none

module te_channel_sched
    import te_sched_pkg::*;
#(
    parameter int unsigned CH_NUM = c_CH_NUM_DEFAULT,
    parameter int unsigned IDX_W  = idx_width(CH_NUM)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              sched_en,
    input  logic [CH_NUM-1:0] ch_mask,
    input  logic [CH_NUM-1:0] set_req,
    output logic              sel_valid,
    input  logic              sel_ready,
    output logic [IDX_W-1:0]  sel_index,
    output logic [CH_NUM-1:0] pending,
`ifdef TE_SCHED_OVERFLOW_EN
    output logic              any_pending,
    output logic [CH_NUM-1:0] ovf_flag,
    input  logic [CH_NUM-1:0] ovf_clr
`else
    output logic              any_pending
`endif
);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [CH_NUM-1:0] r_pending;
    logic [CH_NUM-1:0] w_elig;
    logic [CH_NUM-1:0] w_rot;
    logic [CH_NUM-1:0] w_clr;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_sel_index;
    logic [IDX_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_pick;
    logic              w_found;
    logic              w_hs;
    logic              w_start;

    assign w_elig = r_pending & ch_mask;

    // Rotate so bit 0 of w_rot is the channel at rr_ptr; index sum wraps in IDX_W.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            w_rot[i] = w_elig[IDX_W'(i) + r_rr_ptr];
        end
    end

    least_bit_n #(
        .CH_NUM (CH_NUM),
        .IDX_W  (IDX_W)
    ) u_least_bit (
        .i_vec    (w_rot),
        .o_index  (w_off),
        .o_active (w_found)
    );

    assign w_pick  = r_rr_ptr + w_off;
    assign w_start = (r_state == IDLE) && sched_en && w_found;
    assign w_hs    = (r_state == OFFER) && sel_ready;
    assign w_clr   = w_hs ? ({{(CH_NUM-1){1'b0}}, 1'b1} << r_sel_index) : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)   w_state_nxt = OFFER;
            OFFER:   if (sel_ready) w_state_nxt = RETIRE;
            RETIRE:                 w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_rr_ptr    <= '0;
            r_sel_index <= '0;
        end else begin
            r_state   <= w_state_nxt;
            // Clear before OR so a set arriving with the grant keeps the bit.
            r_pending <= (r_pending & ~w_clr) | set_req;
            if (w_start) begin
                r_sel_index <= w_pick;
            end
            if (w_hs) begin
                r_rr_ptr <= r_sel_index + IDX_W'(1);
            end
        end
    end

    assign sel_valid   = (r_state == OFFER);
    assign sel_index   = r_sel_index;
    assign pending     = r_pending;
    assign any_pending = |w_elig;

`ifdef TE_SCHED_OVERFLOW_EN
    logic [CH_NUM-1:0] r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~ovf_clr) | (set_req & r_pending & ~w_clr);
        end
    end

    assign ovf_flag = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_te_channel_sched.sv
// ============================================================================
// Module  : tb_te_channel_sched
// Brief   : Self-checking bench: directed table, corner sequences, random run
//           against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_te_channel_sched;

    localparam int N = 32;
    localparam logic [31:0] c_ALL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_b, sched_en, sel_ready, sel_valid, any_pending;
    logic [31:0] ch_mask, set_req, pending, ovf_clr;
    logic [4:0]  sel_index;
`ifdef TE_SCHED_OVERFLOW_EN
    logic [31:0] ovf_flag;
`endif

    te_channel_sched #(.CH_NUM(N)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .sched_en    (sched_en),
        .ch_mask     (ch_mask),
        .set_req     (set_req),
        .sel_valid   (sel_valid),
        .sel_ready   (sel_ready),
        .sel_index   (sel_index),
        .pending     (pending),
`ifdef TE_SCHED_OVERFLOW_EN
        .any_pending (any_pending),
        .ovf_flag    (ovf_flag),
        .ovf_clr     (ovf_clr)
`else
        .any_pending (any_pending)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: pending set, current offer (-1 none), one dead cycle after a grant.
    logic [31:0] m_pend, m_ovf;
    int          m_ptr, m_offer, m_last;
    bit          m_gap;
    bit          m_known = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [31:0] elig, input int ptr);
        for (int j = 0; j < N; j++) begin
            if (elig[(ptr + j) % N]) return (ptr + j) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input bit rb, input bit en, input logic [31:0] mask,
                              input logic [31:0] set, input bit rdy, input logic [31:0] oclr);
        logic [31:0] np, no;
        bit          hs;
        int          k;
        if (!rb) begin
            m_pend = '0; m_ovf = '0; m_ptr = 0; m_offer = -1; m_last = 0; m_gap = 1'b0;
            m_known = 1'b1;
            return;
        end
        hs = (m_offer >= 0) && rdy;
        np = m_pend;
        if (hs) np[m_offer] = 1'b0;
        np = np | set;
        for (int i = 0; i < N; i++) begin
            if (set[i] && m_pend[i] && !(hs && m_offer == i)) no[i] = 1'b1;
            else if (oclr[i])                                  no[i] = 1'b0;
            else                                               no[i] = m_ovf[i];
        end
        if (m_offer >= 0) begin
            if (hs) begin
                m_ptr   = (m_offer + 1) % N;
                m_offer = -1;
                m_gap   = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (en) begin
            k = rr_pick(m_pend & mask, m_ptr);
            if (k >= 0) begin
                m_offer = k;
                m_last  = k;
            end
        end
        m_pend = np;
        m_ovf  = no;
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance it.
    task automatic cycle(input bit rb, input bit en, input logic [31:0] mask,
                         input logic [31:0] set, input bit rdy, input logic [31:0] oclr);
        @(negedge clk);
        rst_b = rb; sched_en = en; ch_mask = mask; set_req = set; sel_ready = rdy; ovf_clr = oclr;
        #1;
        if (m_known) begin
            chk("model_valid",   sel_valid,   (m_offer >= 0));
            chk("model_index",   sel_index,   m_last);
            chk("model_pending", pending,     m_pend);
            chk("model_any",     any_pending, |(m_pend & mask));
`ifdef TE_SCHED_OVERFLOW_EN
            chk("model_ovf",     ovf_flag,    m_ovf);
`endif
        end
        model_step(rb, en, mask, set, rdy, oclr);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    typedef struct {
        bit          rb;
        bit          en;
        logic [31:0] mask;
        logic [31:0] set;
        bit          rdy;
        bit          do_chk;
        bit          ev;
        logic [4:0]  ei;
        logic [31:0] ep;
        bit          ea;
    } vec_t;

    vec_t        tbl[6];
    int          gi[$];
    int          gc[$];
    int          exp032[3];
    int          first;
    bit          r_rb, r_en, r_rdy;
    logic [31:0] r_mk, r_st, r_oc;

    initial begin
        rst_b = 1'b0; sched_en = 1'b0; ch_mask = '0; set_req = '0; sel_ready = 1'b0; ovf_clr = '0;

        // Single request on channel 5: pending at +1, offer at +2, cleared at +3.
        tbl[0] = '{1'b0, 1'b1, c_ALL, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0};
        tbl[1] = '{1'b1, 1'b1, c_ALL, 32'h20, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0};
        tbl[2] = '{1'b1, 1'b1, c_ALL, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h20, 1'b1};
        tbl[3] = '{1'b1, 1'b1, c_ALL, 32'h0,  1'b1, 1'b1, 1'b1, 5'd5, 32'h20, 1'b1};
        tbl[4] = '{1'b1, 1'b1, c_ALL, 32'h0,  1'b1, 1'b1, 1'b0, 5'd5, 32'h0,  1'b0};
        tbl[5] = '{1'b1, 1'b1, c_ALL, 32'h0,  1'b1, 1'b1, 1'b0, 5'd5, 32'h0,  1'b0};
        for (int r = 0; r < 6; r++) begin
            cycle(tbl[r].rb, tbl[r].en, tbl[r].mask, tbl[r].set, tbl[r].rdy, '0);
            if (tbl[r].do_chk) begin
                chk("tbl_valid",   sel_valid,   tbl[r].ev);
                chk("tbl_index",   sel_index,   tbl[r].ei);
                chk("tbl_pending", pending,     tbl[r].ep);
                chk("tbl_any",     any_pending, tbl[r].ea);
            end
        end

        // Channels 3, 10, 31 granted in order, three cycles apart.
        do_reset();
        cycle(1'b1, 1'b1, c_ALL, 32'h8000_0408, 1'b1, '0);
        for (int c = 1; c < 20; c++) begin
            cycle(1'b1, 1'b1, c_ALL, '0, 1'b1, '0);
            if (sel_valid && sel_ready) begin
                gi.push_back(int'(sel_index));
                gc.push_back(c);
            end
        end
        exp032 = '{3, 10, 31};
        chk("rr_count", gi.size(), 3);
        if (gi.size() == 3) begin
            for (int g = 0; g < 3; g++) chk("rr_order", gi[g], exp032[g]);
            chk("rr_gap1", gc[1] - gc[0], 3);
            chk("rr_gap2", gc[2] - gc[1], 3);
        end

        // After granting 31, channels 2 and 31 pending: 2 comes next.
        cycle(1'b1, 1'b1, c_ALL, 32'h8000_0004, 1'b1, '0);
        first = -1;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1, 1'b1, c_ALL, '0, 1'b1, '0);
            if (first < 0 && sel_valid) first = int'(sel_index);
        end
        chk("wrap_next", first, 2);

        // Offer of 7 held under back-pressure while mask and enable move.
        do_reset();
        cycle(1'b1, 1'b1, c_ALL, 32'h80, 1'b0, '0);
        cycle(1'b1, 1'b1, c_ALL, '0, 1'b0, '0);
        cycle(1'b1, 1'b1, c_ALL, '0, 1'b0, '0);
        chk("hold_valid0", sel_valid, 1'b1);
        chk("hold_index0", sel_index, 5'd7);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, k[0], 32'hFFFF_FF7F, '0, 1'b0, '0);
            chk("hold_valid", sel_valid, 1'b1);
            chk("hold_index", sel_index, 5'd7);
        end
        cycle(1'b1, 1'b0, 32'hFFFF_FF7F, '0, 1'b1, '0);
        chk("hold_hs_valid", sel_valid, 1'b1);
        cycle(1'b1, 1'b0, 32'hFFFF_FF7F, '0, 1'b0, '0);
        chk("hold_done_valid", sel_valid, 1'b0);
        chk("hold_done_pend7", pending[7], 1'b0);

        // Re-set of channel 4 in its own handshake cycle.
        do_reset();
        cycle(1'b1, 1'b1, c_ALL, 32'h10, 1'b1, '0);
        cycle(1'b1, 1'b1, c_ALL, '0, 1'b1, '0);
        cycle(1'b1, 1'b1, c_ALL, 32'h10, 1'b1, '0);
        chk("reset4_offer", sel_index, 5'd4);
        cycle(1'b1, 1'b1, c_ALL, '0, 1'b1, '0);
        chk("reset4_pend", pending[4], 1'b1);
        chk("reset4_retire", sel_valid, 1'b0);
`ifdef TE_SCHED_OVERFLOW_EN
        chk("reset4_ovf", ovf_flag[4], 1'b0);
`endif
        cycle(1'b1, 1'b1, c_ALL, '0, 1'b0, '0);
        chk("reset4_idle", sel_valid, 1'b0);
        cycle(1'b1, 1'b1, c_ALL, '0, 1'b0, '0);
        chk("reset4_reoffer_v", sel_valid, 1'b1);
        chk("reset4_reoffer_i", sel_index, 5'd4);
        cycle(1'b1, 1'b1, c_ALL, '0, 1'b1, '0);

        // Reset while offering channel 9, with a set_req that must be ignored.
        do_reset();
        cycle(1'b1, 1'b1, c_ALL, 32'h200, 1'b1, '0);
        cycle(1'b1, 1'b1, c_ALL, '0, 1'b0, '0);
        cycle(1'b1, 1'b1, c_ALL, '0, 1'b0, '0);
        chk("rst9_offer", sel_index, 5'd9);
        cycle(1'b0, 1'b1, c_ALL, 32'h200, 1'b1, '0);
        cycle(1'b1, 1'b1, c_ALL, '0, 1'b1, '0);
        chk("rst9_valid", sel_valid, 1'b0);
        chk("rst9_index", sel_index, 5'd0);
        chk("rst9_pend",  pending, 32'h0);
        chk("rst9_any",   any_pending, 1'b0);
        cycle(1'b1, 1'b1, c_ALL, '0, 1'b1, '0);
        chk("rst9_stay_idle", sel_valid, 1'b0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            r_rb  = ($urandom_range(0, 299) != 0);
            r_en  = ($urandom_range(0, 7) != 0);
            r_mk  = $urandom | $urandom;
            if (c % 7 == 0) r_mk = $urandom & $urandom;
            r_st  = $urandom & $urandom & $urandom & $urandom;
            if (((c / 250) % 2) == 1) r_st = r_st & $urandom & $urandom & $urandom;
            r_rdy = $urandom_range(0, 1) != 0;
            r_oc  = $urandom & $urandom & $urandom;
            cycle(r_rb, r_en, r_mk, r_st, r_rdy, r_oc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
